// File: rtl/ysyx_22051013_fetch_ctrl_pkg.sv
// Shared widths, reset constants and state encoding for the fetch sequencer.
// The optional YSYX_22051013_FETCH_PERF_EN counters also use CNT_W from here.
package ysyx_22051013_fetch_ctrl_pkg;

    localparam int unsigned PC_W   = 64;
    localparam int unsigned INST_W = 32;
    localparam int unsigned CNT_W  = 64;

    localparam logic [PC_W-1:0]   RESET_PC_DEF = 64'h8000_0000;
    localparam logic [INST_W-1:0] NOP_INST     = 32'h0000_0013;

    typedef enum logic [1:0] {
        ST_BOOT = 2'd0,
        ST_REQ  = 2'd1,
        ST_WAIT = 2'd2,
        ST_OUT  = 2'd3
    } fetch_state_e;

    // Redirect targets are always word aligned.
    function automatic logic [PC_W-1:0] align_pc(input logic [PC_W-1:0] pc);
        return {pc[PC_W-1:2], 2'b00};
    endfunction

endpackage

// File: rtl/ysyx_22051013_fetch_ctrl_if.sv
// Fetch-stage bus bundle: instruction memory, static BPU, redirects and IF/ID.
interface ysyx_22051013_fetch_ctrl_if;
    import ysyx_22051013_fetch_ctrl_pkg::*;

    logic              imem_req_valid;
    logic              imem_req_ready;
    logic [PC_W-1:0]   imem_req_addr;
    logic              imem_resp_valid;
    logic [INST_W-1:0] imem_resp_inst;
    logic [INST_W-1:0] bpu_inst;
    logic [PC_W-1:0]   bpu_pc;
    logic [PC_W-1:0]   bpu_pc_next;
    logic              bpu_jump;
    logic              redir_trap_valid;
    logic [PC_W-1:0]   redir_trap_pc;
    logic              redir_exu_valid;
    logic [PC_W-1:0]   redir_exu_pc;
    logic              if_valid;
    logic              if_ready;
    logic [INST_W-1:0] if_inst;
    logic [PC_W-1:0]   if_pc;
    logic              if_pred_taken;

    modport master (
        output imem_req_valid, imem_req_addr, bpu_inst, bpu_pc,
               if_valid, if_inst, if_pc, if_pred_taken,
        input  imem_req_ready, imem_resp_valid, imem_resp_inst,
               bpu_pc_next, bpu_jump,
               redir_trap_valid, redir_trap_pc, redir_exu_valid, redir_exu_pc,
               if_ready
    );

    modport slave (
        input  imem_req_valid, imem_req_addr, bpu_inst, bpu_pc,
               if_valid, if_inst, if_pc, if_pred_taken,
        output imem_req_ready, imem_resp_valid, imem_resp_inst,
               bpu_pc_next, bpu_jump,
               redir_trap_valid, redir_trap_pc, redir_exu_valid, redir_exu_pc,
               if_ready
    );

endinterface

// File: rtl/ysyx_22051013_fetch_perf.sv
// Saturating fetch/redirect/drop event counters for the fetch sequencer.
module ysyx_22051013_fetch_perf
    import ysyx_22051013_fetch_ctrl_pkg::*;
(
    input  logic             clk,
    input  logic             rst,
    input  logic             fetch_inc,
    input  logic             redir_inc,
    input  logic             drop_inc,
    output logic [CNT_W-1:0] fetch_cnt,
    output logic [CNT_W-1:0] redir_cnt,
    output logic [CNT_W-1:0] drop_cnt
);

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            fetch_cnt <= '0;
            redir_cnt <= '0;
            drop_cnt  <= '0;
        end else begin
            if (fetch_inc && !(&fetch_cnt)) fetch_cnt <= fetch_cnt + CNT_W'(1);
            if (redir_inc && !(&redir_cnt)) redir_cnt <= redir_cnt + CNT_W'(1);
            if (drop_inc  && !(&drop_cnt))  drop_cnt  <= drop_cnt  + CNT_W'(1);
        end
    end

endmodule

// File: rtl/ysyx_22051013_fetch_ctrl.sv
// Fetch sequencer: one outstanding imem request, BPU-steered next PC, redirects.
// Define YSYX_22051013_FETCH_PERF_EN to add the perf_* counter ports.
module ysyx_22051013_fetch_ctrl
    import ysyx_22051013_fetch_ctrl_pkg::*;
#(
    parameter logic [PC_W-1:0] START_PC = RESET_PC_DEF
) (
    input logic clk,
    input logic rst,
    ysyx_22051013_fetch_ctrl_if.master bus
`ifdef YSYX_22051013_FETCH_PERF_EN
    ,
    output logic [CNT_W-1:0] perf_fetch_cnt,
    output logic [CNT_W-1:0] perf_redir_cnt,
    output logic [CNT_W-1:0] perf_drop_cnt
`endif
);

    fetch_state_e      state;
    logic [PC_W-1:0]   pc_r;
    logic [INST_W-1:0] inst_buf;
    logic              kill;

    logic              redir_c;
    logic [PC_W-1:0]   redir_pc_c;

    // Redirect priority: trap over EXU; the BPU prediction is taken only in OUT.
    always_comb begin
        redir_c    = 1'b0;
        redir_pc_c = pc_r;
        if (bus.redir_trap_valid) begin
            redir_c    = 1'b1;
            redir_pc_c = align_pc(bus.redir_trap_pc);
        end else if (bus.redir_exu_valid) begin
            redir_c    = 1'b1;
            redir_pc_c = align_pc(bus.redir_exu_pc);
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state    <= ST_BOOT;
            pc_r     <= START_PC;
            inst_buf <= NOP_INST;
            kill     <= 1'b0;
        end else begin
            case (state)
                ST_BOOT: state <= ST_REQ;
                ST_REQ: begin
                    if (redir_c) pc_r <= redir_pc_c;
                    if (bus.imem_req_ready) begin
                        state <= ST_WAIT;
                        kill  <= redir_c;
                    end
                end
                ST_WAIT: begin
                    if (redir_c) pc_r <= redir_pc_c;
                    if (bus.imem_resp_valid) begin
                        kill <= 1'b0;
                        if (kill || redir_c) begin
                            state <= ST_REQ;
                        end else begin
                            inst_buf <= bus.imem_resp_inst;
                            state    <= ST_OUT;
                        end
                    end else if (redir_c) begin
                        kill <= 1'b1;
                    end
                end
                ST_OUT: begin
                    if (redir_c) begin
                        pc_r     <= redir_pc_c;
                        inst_buf <= NOP_INST;
                        state    <= ST_REQ;
                    end else if (bus.if_ready) begin
                        pc_r  <= bus.bpu_pc_next;
                        state <= ST_REQ;
                    end
                end
                default: state <= ST_BOOT;
            endcase
        end
    end

    // Outputs decode the registered state; a redirect masks if_valid in the same cycle.
    always_comb begin
        bus.imem_req_valid = (state == ST_REQ);
        bus.imem_req_addr  = pc_r;
        bus.if_valid       = (state == ST_OUT) && !redir_c;
        bus.if_inst        = (state == ST_OUT) ? inst_buf : NOP_INST;
        bus.if_pc          = (state == ST_OUT) ? pc_r : '0;
        bus.if_pred_taken  = (state == ST_OUT) && bus.bpu_jump;
        bus.bpu_inst       = (state == ST_OUT) ? inst_buf : NOP_INST;
        bus.bpu_pc         = pc_r;
    end

`ifdef YSYX_22051013_FETCH_PERF_EN
    logic fetch_ev_c;
    logic redir_ev_c;
    logic drop_ev_c;

    always_comb begin
        fetch_ev_c = (state == ST_OUT) && !redir_c && bus.if_ready;
        redir_ev_c = (state != ST_BOOT) && bus.redir_exu_valid && !bus.redir_trap_valid;
        drop_ev_c  = (state == ST_WAIT) && bus.imem_resp_valid && (kill || redir_c);
    end

    ysyx_22051013_fetch_perf u_perf (
        .clk       (clk),
        .rst       (rst),
        .fetch_inc (fetch_ev_c),
        .redir_inc (redir_ev_c),
        .drop_inc  (drop_ev_c),
        .fetch_cnt (perf_fetch_cnt),
        .redir_cnt (perf_redir_cnt),
        .drop_cnt  (perf_drop_cnt)
    );
`endif

endmodule

// File: tb/tb_ysyx_22051013_fetch_ctrl.sv
// Directed bench for the fetch sequencer with a transaction-level scoreboard.
module tb_ysyx_22051013_fetch_ctrl;

    localparam logic [31:0] NOP = 32'h0000_0013;
    localparam logic [31:0] JAL16 = 32'h0100_006F;

    logic clk = 1'b0;
    logic rst;
    int   checks = 0;
    int   errors = 0;
    int   lat = 1;
    int   cyc = 0;
    logic [31:0] word0;

    ysyx_22051013_fetch_ctrl_if bus ();

`ifdef YSYX_22051013_FETCH_PERF_EN
    logic [63:0] perf_fetch_cnt, perf_redir_cnt, perf_drop_cnt;
    ysyx_22051013_fetch_ctrl dut (.clk(clk), .rst(rst), .bus(bus),
        .perf_fetch_cnt(perf_fetch_cnt), .perf_redir_cnt(perf_redir_cnt),
        .perf_drop_cnt(perf_drop_cnt));
`else
    ysyx_22051013_fetch_ctrl dut (.clk(clk), .rst(rst), .bus(bus));
`endif

    always #5 clk = ~clk;

    // Static BPU stand-in: only the jal +16 encoding is predicted taken.
    assign bus.bpu_jump    = (bus.bpu_inst == JAL16);
    assign bus.bpu_pc_next = bus.bpu_pc + (bus.bpu_jump ? 64'd16 : 64'd4);

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h want %h at %0t", name, act, exp, $time);
        end
    endtask

    function automatic logic [31:0] mem_word(input logic [63:0] a);
        if (a == 64'h8000_0000) return word0;
        return {a[23:0], 8'h13};
    endfunction

    // Memory: responds lat cycles after each accepted request.
    typedef struct { int due; logic [63:0] addr; } mreq_t;
    mreq_t mq[$];

    always @(negedge clk) begin
        mreq_t t;
        #1;
        cyc++;
        bus.imem_resp_valid = 1'b0;
        if (mq.size() > 0 && mq[0].due == cyc) begin
            bus.imem_resp_valid = 1'b1;
            bus.imem_resp_inst  = mem_word(mq[0].addr);
            void'(mq.pop_front());
        end
        if (rst && bus.imem_req_valid && bus.imem_req_ready) begin
            t.due  = cyc + lat;
            t.addr = bus.imem_req_addr;
            mq.push_back(t);
        end
    end

    // Scoreboard: outstanding fetches, the held instruction and the architectural PC.
    typedef struct { logic [63:0] addr; bit stale; } oent_t;
    oent_t       oq[$];
    logic [63:0] m_pc;
    bit          m_hold;
    bit          m_boot;
    logic [31:0] m_hold_inst;
    logic [63:0] m_hold_pc;

    always @(negedge clk) begin
        bit          redir, exp_req, old_hold;
        logic [63:0] tgt, req_pc;
        oent_t       e;
        #2;
        if (!rst) begin
            chk("rst_req_valid", 64'(bus.imem_req_valid), 64'd0);
            chk("rst_if_valid", 64'(bus.if_valid), 64'd0);
            chk("rst_if_inst", 64'(bus.if_inst), 64'(NOP));
            chk("rst_bpu_inst", 64'(bus.bpu_inst), 64'(NOP));
            chk("rst_if_pc", bus.if_pc, 64'd0);
            m_pc = 64'h8000_0000; m_hold = 0; m_boot = 1; oq.delete();
        end else begin
            redir   = bus.redir_trap_valid || bus.redir_exu_valid;
            tgt     = (bus.redir_trap_valid ? bus.redir_trap_pc : bus.redir_exu_pc) & ~64'd3;
            req_pc  = m_pc;
            exp_req = !m_boot && oq.size() == 0 && !m_hold;
            chk("req_valid", 64'(bus.imem_req_valid), 64'(exp_req));
            if (exp_req && bus.imem_req_valid) chk("req_addr", bus.imem_req_addr, m_pc);
            chk("if_valid", 64'(bus.if_valid), 64'(m_hold && !redir));
            if (m_hold) begin
                chk("if_inst", 64'(bus.if_inst), 64'(m_hold_inst));
                chk("if_pc", bus.if_pc, m_hold_pc);
                chk("bpu_inst", 64'(bus.bpu_inst), 64'(m_hold_inst));
                chk("bpu_pc", bus.bpu_pc, m_hold_pc);
                chk("if_pred", 64'(bus.if_pred_taken), 64'(m_hold_inst == JAL16));
            end else begin
                chk("bpu_inst_idle", 64'(bus.bpu_inst), 64'(NOP));
                chk("bpu_pc_idle", bus.bpu_pc, m_pc);
            end
            if (m_boot) begin
                m_boot = 0;
            end else begin
                old_hold = m_hold;
                if (old_hold && !redir && bus.if_ready) begin
                    m_pc   = m_hold_pc + ((m_hold_inst == JAL16) ? 64'd16 : 64'd4);
                    m_hold = 0;
                end
                if (bus.imem_resp_valid && oq.size() > 0) begin
                    e = oq.pop_front();
                    if (!e.stale && !redir) begin
                        m_hold = 1; m_hold_inst = bus.imem_resp_inst; m_hold_pc = e.addr;
                    end
                end
                if (redir) begin
                    m_pc = tgt; m_hold = 0;
                    foreach (oq[i]) oq[i].stale = 1'b1;
                end
                if (exp_req && bus.imem_req_ready) begin
                    e.addr = req_pc; e.stale = redir;
                    oq.push_back(e);
                end
            end
        end
    end

    task automatic tick();
        @(negedge clk);
    endtask

    // Called at a negedge; returns 3 time units after the cycle that issued a request.
    task automatic expect_req(input logic [63:0] a, input string name, input bit no_ifv);
        bit seen = 0;
        for (int i = 0; i < 30 && !seen; i++) begin
            if (i > 0) @(negedge clk);
            #3;
            if (no_ifv) chk({name, "_no_ifv"}, 64'(bus.if_valid), 64'd0);
            if (bus.imem_req_valid) begin
                seen = 1;
                chk(name, bus.imem_req_addr, a);
            end
        end
        chk({name, "_timeout"}, 64'(seen), 64'd1);
    endtask

    task automatic wait_ifv(input logic [63:0] pc, input logic [31:0] inst, input string name);
        bit seen = 0;
        for (int i = 0; i < 30 && !seen; i++) begin
            if (i > 0) @(negedge clk);
            #3;
            if (bus.if_valid) begin
                seen = 1;
                chk({name, "_pc"}, bus.if_pc, pc);
                chk({name, "_inst"}, 64'(bus.if_inst), 64'(inst));
            end
        end
        chk({name, "_timeout"}, 64'(seen), 64'd1);
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: bench did not finish");
        $fatal(1);
    end

    initial begin
        rst = 1'b0; word0 = NOP;
        bus.imem_req_ready = 1'b1; bus.if_ready = 1'b1;
        bus.redir_trap_valid = 1'b0; bus.redir_trap_pc = '0;
        bus.redir_exu_valid = 1'b0; bus.redir_exu_pc = '0;
        bus.imem_resp_valid = 1'b0; bus.imem_resp_inst = '0;
        tick(); #3;
        chk("lit_reset_if_inst", 64'(bus.if_inst), 64'h13);
        chk("lit_reset_req_valid", 64'(bus.imem_req_valid), 64'd0);

        // Straight-line fetch from the reset PC
        tick(); rst = 1'b1;
        expect_req(64'h8000_0000, "t1_req0", 1'b0);
        tick(); wait_ifv(64'h8000_0000, NOP, "t1_if");
        tick(); expect_req(64'h8000_0004, "t1_req1", 1'b0);

        // Trap back to the reset PC, now holding jal +16
        tick(); word0 = JAL16; bus.redir_trap_valid = 1'b1; bus.redir_trap_pc = 64'h8000_0000;
        tick(); bus.redir_trap_valid = 1'b0;
        expect_req(64'h8000_0000, "t2_req", 1'b0);
        tick(); wait_ifv(64'h8000_0000, JAL16, "t2_if");
        chk("t2_pred", 64'(bus.if_pred_taken), 64'd1);
        tick(); expect_req(64'h8000_0010, "t2_target", 1'b0);

        // IF/ID back-pressure holds the output stable
        tick(); bus.if_ready = 1'b0;
        wait_ifv(64'h8000_0010, 32'h0000_1013, "t3_if");
        for (int i = 0; i < 3; i++) begin
            tick(); #3;
            chk("t3_hold_valid", 64'(bus.if_valid), 64'd1);
            chk("t3_hold_inst", 64'(bus.if_inst), 64'h0000_1013);
            chk("t3_hold_pc", bus.if_pc, 64'h8000_0010);
            chk("t3_no_req", 64'(bus.imem_req_valid), 64'd0);
        end
        tick(); bus.if_ready = 1'b1; lat = 3;
        expect_req(64'h8000_0014, "t3_next", 1'b0);

        // EXU redirect while waiting; the late response is discarded
        tick(); bus.redir_exu_valid = 1'b1; bus.redir_exu_pc = 64'h8000_0102;
        tick(); bus.redir_exu_valid = 1'b0;
        expect_req(64'h8000_0100, "t4_req", 1'b1);

        // Trap beats EXU in OUT; if_ready in that cycle is not a transfer
        tick(); lat = 1; bus.if_ready = 1'b0;
        wait_ifv(64'h8000_0100, 32'h0001_0013, "t5_if");
        tick();
        bus.redir_trap_valid = 1'b1; bus.redir_trap_pc = 64'h8000_0200;
        bus.redir_exu_valid = 1'b1; bus.redir_exu_pc = 64'h8000_0100;
        bus.if_ready = 1'b1;
        #3 chk("t5_masked", 64'(bus.if_valid), 64'd0);
        tick(); bus.redir_trap_valid = 1'b0; bus.redir_exu_valid = 1'b0;
        expect_req(64'h8000_0200, "t5_req", 1'b1);

        // Reset in WAIT; the late response lands while the port is idle
        tick(); lat = 4;
        expect_req(64'h8000_0204, "t6_pre", 1'b0);
        tick(); rst = 1'b0;
        #3;
        chk("t6_rst_req", 64'(bus.imem_req_valid), 64'd0);
        chk("t6_rst_ifv", 64'(bus.if_valid), 64'd0);
        tick();
        tick(); rst = 1'b1; bus.imem_req_ready = 1'b0; lat = 1;
        tick();
        tick(); bus.imem_req_ready = 1'b1;
        expect_req(64'h8000_0000, "t6_req", 1'b0);
        tick(); wait_ifv(64'h8000_0000, JAL16, "t6_if");
        tick(); expect_req(64'h8000_0010, "t6_next", 1'b0);

        repeat (3) tick();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
